// File: rtl/prbs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prbs_pkg
// Purpose  : Shared types and constants for the PRBS checker slice.
//            - state_t : checker FSM states (SEED, HUNT, LOCKED)
//            - POLY4/POLY7 : default Fibonacci tap masks (bit i = stage i)
//            - cnt_w() : width needed to hold a counter value 0..max_val
// Revision : 1.0 - initial release
// ============================================================================
package prbs_pkg;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // x^4+x^3+1 (period 15) and x^7+x^6+1 (period 127)
    localparam logic [3:0] POLY4 = 4'b1100;
    localparam logic [6:0] POLY7 = 7'b1100000;

    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_predict.sv
`default_nettype none
// ============================================================================
// Module   : prbs_predict
// Purpose  : Combinational next-bit predictor for a Fibonacci LFSR.
//            pred = XOR of the shift-register stages selected by POLY.
// Ports    : sr   in  [WIDTH-1:0]  current shift register (sr[0] = newest bit)
//            pred out 1            predicted next stream bit
// Revision : 1.0 - initial release
// ============================================================================
module prbs_predict
    import prbs_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] POLY  = POLY4
) (
    input  logic [WIDTH-1:0] sr,
    output logic             pred
);

    assign pred = ^(sr & POLY);

endmodule
`default_nettype wire

// File: rtl/prbs_checker.sv
`default_nettype none
// ============================================================================
// Module   : prbs_checker
// Purpose  : Serial PRBS receiver/checker. Seeds its shift register from the
//            incoming stream, hunts for LOCK_CNT consecutive correct
//            predictions, then flywheels on its own prediction while counting
//            mismatches. Lock drops after LOSS_CNT consecutive mismatches.
// Ports    : clk        in   1      clock, rising edge
//            rst        in   1      asynchronous active-high reset
//            din_vld    in   1      din carries a valid stream bit
//            din        in   1      received serial PRBS bit
//            clr_cnt    in   1      synchronous clear of err_cnt (and bit_cnt)
//            locked     out  1      checker is in LOCKED
//            err_pulse  out  1      one-cycle pulse per mismatch while LOCKED
//            err_cnt    out  CNT_W  saturating mismatch count while LOCKED
//            bit_cnt    out  CNT_W  saturating count of bits checked while
//                                   LOCKED (only with PRBS_CHECKER_BITCNT_EN)
// Config   : define PRBS_CHECKER_BITCNT_EN to add the bit_cnt port/counter.
// Revision : 1.0 - initial release
// ============================================================================
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] POLY     = POLY4,
    parameter int               LOCK_CNT = 8,
    parameter int               LOSS_CNT = 4,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_vld,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
`ifdef PRBS_CHECKER_BITCNT_EN
    output logic [CNT_W-1:0] bit_cnt,
`endif
    output logic [CNT_W-1:0] err_cnt
);

    // run counter doubles as the seed-bit counter in SEED, so it must reach
    // whichever of WIDTH / LOCK_CNT is larger
    localparam int c_RUN_W  = cnt_w((LOCK_CNT > WIDTH) ? LOCK_CNT : WIDTH);
    localparam int c_MISS_W = cnt_w(LOSS_CNT);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    sr_q, sr_d;
    logic [c_RUN_W-1:0]  run_q, run_d;
    logic [c_MISS_W-1:0] miss_q, miss_d;
    logic                locked_q, locked_d;
    logic                err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
`ifdef PRBS_CHECKER_BITCNT_EN
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
`endif

    logic                w_pred;
    logic [WIDTH-1:0]    w_sr_din;
    logic [c_RUN_W-1:0]  w_run_inc;
    logic [c_MISS_W-1:0] w_miss_inc;

    prbs_predict #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_predict (
        .sr    (sr_q),
        .pred  (w_pred)
    );

    assign w_sr_din   = {sr_q[WIDTH-2:0], din};
    assign w_run_inc  = run_q + 1'b1;
    assign w_miss_inc = miss_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        run_d       = run_q;
        miss_d      = miss_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
`ifdef PRBS_CHECKER_BITCNT_EN
        bit_cnt_d   = bit_cnt_q;
`endif

        if (din_vld) begin
            case (state_q)
                SEED: begin
                    sr_d = w_sr_din;
                    if (run_q == c_RUN_W'(WIDTH - 1)) begin
                        run_d = '0;
                        // an all-zero seed is the LFSR lock-up state; collect again
                        if (w_sr_din != '0) begin
                            state_d = HUNT;
                        end
                    end else begin
                        run_d = w_run_inc;
                    end
                end
                HUNT: begin
                    sr_d = w_sr_din;
                    if (din == w_pred) begin
                        if (w_run_inc == c_RUN_W'(LOCK_CNT)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            run_d    = '0;
                            miss_d   = '0;
                        end else begin
                            run_d = w_run_inc;
                        end
                    end else begin
                        state_d = SEED;
                        run_d   = '0;
                    end
                end
                LOCKED: begin
                    // flywheel: feed back our own prediction so a single
                    // corrupted bit cannot poison later predictions
                    sr_d = {sr_q[WIDTH-2:0], w_pred};
`ifdef PRBS_CHECKER_BITCNT_EN
                    if (bit_cnt_q != c_CNT_MAX) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
`endif
                    if (din != w_pred) begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != c_CNT_MAX) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                        if (w_miss_inc == c_MISS_W'(LOSS_CNT)) begin
                            state_d  = SEED;
                            locked_d = 1'b0;
                            miss_d   = '0;
                            run_d    = '0;
                        end else begin
                            miss_d = w_miss_inc;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: begin
                    state_d  = SEED;
                    locked_d = 1'b0;
                    run_d    = '0;
                    miss_d   = '0;
                end
            endcase
        end

        // clear takes priority over a same-cycle increment
        if (clr_cnt) begin
            err_cnt_d = '0;
`ifdef PRBS_CHECKER_BITCNT_EN
            bit_cnt_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SEED;
            sr_q        <= '0;
            run_q       <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
`ifdef PRBS_CHECKER_BITCNT_EN
            bit_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
`ifdef PRBS_CHECKER_BITCNT_EN
            bit_cnt_q   <= bit_cnt_d;
`endif
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
`ifdef PRBS_CHECKER_BITCNT_EN
    assign bit_cnt   = bit_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prbs_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbs_checker
// Purpose  : Self-checking bench for prbs_checker. A bench-side generator
//            drives a PRBS stream with optional bit flips, din_vld gaps and
//            clr_cnt pulses; a behavioural model (bit-history queue) predicts
//            locked / err_pulse / err_cnt (and bit_cnt when
//            PRBS_CHECKER_BITCNT_EN is defined) after every clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prbs_checker;

    localparam int         WIDTH    = 4;
    localparam logic [3:0] POLY     = 4'b1100;
    localparam int         LOCK_CNT = 8;
    localparam int         LOSS_CNT = 4;
    localparam int         CNT_W    = 4;
    localparam int         SAT      = (1 << CNT_W) - 1;

    logic             clk     = 1'b0;
    logic             rst     = 1'b1;
    logic             din_vld = 1'b0;
    logic             din     = 1'b0;
    logic             clr_cnt = 1'b0;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
`ifdef PRBS_CHECKER_BITCNT_EN
    logic [CNT_W-1:0] bit_cnt;
`endif

    always #5 clk = ~clk;

    prbs_checker #(
        .WIDTH    (WIDTH),
        .POLY     (POLY),
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din_vld   (din_vld),
        .din       (din),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
`ifdef PRBS_CHECKER_BITCNT_EN
        .bit_cnt   (bit_cnt),
`endif
        .err_cnt   (err_cnt)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_mode: 0 = seeding, 1 = hunting, 2 = locked
    int m_mode, m_count, m_miss, m_err, m_bits;
    bit m_pulse;
    bit m_hist[$];   // m_hist[k] = bit that entered k steps ago

    task automatic m_reset();
        m_mode = 0; m_count = 0; m_miss = 0; m_err = 0; m_bits = 0; m_pulse = 0;
        m_hist.delete();
        for (int i = 0; i < WIDTH; i++) m_hist.push_back(1'b0);
    endtask

    task automatic m_push(input bit b);
        m_hist.push_front(b);
        m_hist.delete(WIDTH);
    endtask

    task automatic m_step(input bit vld, input bit d, input bit clr);
        bit p;
        bit nonzero;
        m_pulse = 0;
        if (vld) begin
            p = 0;
            for (int i = 0; i < WIDTH; i++) if (POLY[i]) p ^= m_hist[i];
            if (m_mode == 0) begin
                m_push(d);
                m_count++;
                if (m_count == WIDTH) begin
                    m_count = 0;
                    nonzero = 0;
                    for (int i = 0; i < WIDTH; i++) nonzero |= m_hist[i];
                    if (nonzero) m_mode = 1;
                end
            end else if (m_mode == 1) begin
                m_push(d);
                if (d == p) begin
                    m_count++;
                    if (m_count == LOCK_CNT) begin
                        m_mode = 2; m_count = 0; m_miss = 0;
                    end
                end else begin
                    m_mode = 0; m_count = 0;
                end
            end else begin
                m_push(p);
                if (m_bits < SAT) m_bits++;
                if (d != p) begin
                    m_pulse = 1;
                    if (m_err < SAT) m_err++;
                    m_miss++;
                    if (m_miss == LOSS_CNT) begin
                        m_mode = 0; m_miss = 0; m_count = 0;
                    end
                end else begin
                    m_miss = 0;
                end
            end
        end
        if (clr) begin
            m_err = 0; m_bits = 0;
        end
    endtask

    // ---------------- stream generator ----------------
    int unsigned g = 1;

    task automatic gen_next(output bit b);
        b = 0;
        for (int i = 0; i < WIDTH; i++) if (POLY[i]) b ^= g[i];
        g = ((g << 1) | b) & ((1 << WIDTH) - 1);
    endtask

    // apply one cycle of stimulus, then compare all outputs with the model
    task automatic send(input bit vld, input bit flip, input bit clr);
        bit d;
        d = 0;
        if (vld) begin
            gen_next(d);
            d ^= flip;
        end
        din_vld = vld;
        din     = d;
        clr_cnt = clr;
        @(posedge clk);
        m_step(vld, d, clr);
        #1;
        chk("locked", locked, (m_mode == 2));
        chk("err_pulse", err_pulse, m_pulse);
        chk("err_cnt", err_cnt, m_err);
`ifdef PRBS_CHECKER_BITCNT_EN
        chk("bit_cnt", bit_cnt, m_bits);
`endif
    endtask

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst = 1'b0;

        // initial acquisition: 4 seed bits + 8 matches
        repeat (11) send(1, 0, 0);
        chk("prelock", locked, 0);
        send(1, 0, 0);
        chk("lock12", locked, 1);
        chk("lock12_err", err_cnt, 0);

        // single flipped bit -> exactly one error, lock kept
        repeat (5) send(1, 0, 0);
        send(1, 1, 0);
        chk("flip_pulse", err_pulse, 1);
        chk("flip_err", err_cnt, 1);
        send(1, 0, 0);
        chk("flip_pulse_drop", err_pulse, 0);
        chk("flip_locked", locked, 1);

        // din_vld gaps while locked produce no errors
        repeat (10) begin
            send(0, 0, 0);
            send(1, 0, 0);
        end
        chk("gap_err", err_cnt, 1);
        chk("gap_locked", locked, 1);

        // four consecutive mismatches drop lock, errors stay counted
        repeat (4) send(1, 1, 0);
        chk("loss_locked", locked, 0);
        chk("loss_err", err_cnt, 5);
        repeat (11) send(1, 0, 0);
        chk("relock_pre", locked, 0);
        send(1, 0, 0);
        chk("relock12", locked, 1);

        // saturation: 20 isolated errors on a cleared counter
        send(1, 0, 1);
        chk("clr_err", err_cnt, 0);
        repeat (20) begin
            send(1, 1, 0);
            send(1, 0, 0);
        end
        chk("sat_err", err_cnt, SAT);
        chk("sat_locked", locked, 1);

        // clear and error in the same cycle: clear wins, pulse still fires
        send(1, 1, 1);
        chk("clr_vs_err_cnt", err_cnt, 0);
        chk("clr_vs_err_pulse", err_pulse, 1);
        send(1, 0, 0);

`ifdef PRBS_CHECKER_BITCNT_EN
        send(1, 0, 1);
        repeat (30) send(1, 0, 0);
        chk("bitcnt30", bit_cnt, (30 < SAT) ? 30 : SAT);
`endif

        // randomized traffic: gaps, sparse flips, occasional clears
        repeat (400) begin
            send(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 31) == 0));
        end

        // clean data to regain lock, then asynchronous reset mid-lock
        repeat (40) send(1, 0, 0);
        chk("prerst_locked", locked, 1);
        send(1, 1, 0);
        rst = 1'b1;
        #2;
        chk("arst_locked", locked, 0);
        chk("arst_err_cnt", err_cnt, 0);
        chk("arst_err_pulse", err_pulse, 0);
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (11) send(1, 0, 0);
        chk("rst_relock_pre", locked, 0);
        send(1, 0, 0);
        chk("rst_relock", locked, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
